// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer for one shared multi-cycle signed multiplier.
// Two requesters, operands held for the multiplier's latency, responses tagged with requester ID.
module mul_share_ctrl #(
  parameter int AW  = 4,
  parameter int PW  = 7,
  parameter int LAT = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*AW-1:0] req_a,
  input  logic [2*AW-1:0] req_b,
  output logic [AW-1:0]   mul_a,
  output logic [AW-1:0]   mul_b,
  output logic            mul_en,
  input  logic [PW-1:0]   mul_p,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [PW-1:0]   rsp_p,
  output logic            rsp_id,
  output logic            busy
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [AW-1:0]   mul_a_q,     mul_a_d;
  logic [AW-1:0]   mul_b_q,     mul_b_d;
  logic            mul_en_q,    mul_en_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]   rsp_p_q,     rsp_p_d;
  logic            rsp_id_q,    rsp_id_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic            last_id_q,   last_id_d;
  logic            id_q,        id_d;

  logic            gnt_valid;
  logic            gnt_id;

  // Arbitration only happens in IDLE; a tie goes to whoever was not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == IDLE) begin
      case (req_valid)
        2'b01:   begin gnt_valid = 1'b1; gnt_id = 1'b0;       end
        2'b10:   begin gnt_valid = 1'b1; gnt_id = 1'b1;       end
        2'b11:   begin gnt_valid = 1'b1; gnt_id = ~last_id_q; end
        default: ;
      endcase
    end
  end

  assign req_ready = {gnt_valid & gnt_id, gnt_valid & ~gnt_id};

  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_en_d    = mul_en_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    cnt_d       = cnt_q;
    last_id_d   = last_id_q;
    id_d        = id_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          mul_a_d   = gnt_id ? req_a[2*AW-1:AW] : req_a[AW-1:0];
          mul_b_d   = gnt_id ? req_b[2*AW-1:AW] : req_b[AW-1:0];
          id_d      = gnt_id;
          last_id_d = gnt_id;
          cnt_d     = '0;
          mul_en_d  = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Capture one edge after the count reaches LAT, giving LAT+1 cycles of settling.
        if (cnt_q == CW'(LAT)) begin
          rsp_p_d     = mul_p;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          mul_en_d    = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= 1'b0;
      cnt_q       <= '0;
      last_id_q   <= 1'b1;
      id_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_en_q    <= mul_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      cnt_q       <= cnt_d;
      last_id_q   <= last_id_d;
      id_q        <= id_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_en    = mul_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a delay-line model of the shared multiplier.
module tb_mul_share_ctrl;

  localparam int AW  = 4;
  localparam int PW  = 7;
  localparam int LAT = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*AW-1:0] req_a;
  logic [2*AW-1:0] req_b;
  logic [AW-1:0]   mul_a;
  logic [AW-1:0]   mul_b;
  logic            mul_en;
  logic [PW-1:0]   mul_p;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [PW-1:0]   rsp_p;
  logic            rsp_id;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mul_share_ctrl #(.AW(AW), .PW(PW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_en    (mul_en),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] prod(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic signed [7:0] sa, sb, p;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    p  = sa * sb;
    return p[PW-1:0];
  endfunction

  // Multiplier: product of the operands appears LAT edges after they settle.
  logic [PW-1:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= prod(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for rsp_valid; n is the number of edges taken.
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [AW-1:0] op_a   [6] = '{4'h5, 4'hC, 4'h7, 4'h8, 4'h6, 4'h8};
  logic [AW-1:0] op_b   [6] = '{4'h3, 4'h5, 4'hF, 4'h7, 4'h6, 4'h8};
  logic [PW-1:0] op_exp [6] = '{7'h0F, 7'h6C, 7'h79, 7'h48, 7'h24, 7'h40};

  initial begin
    int n;
    int t0;
    logic exp_id;

    rst_n     = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mul_a",     32'(mul_a),     32'd0);
    check("rst_mul_b",     32'(mul_b),     32'd0);
    check("rst_mul_en",    32'(mul_en),    32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_p",     32'(rsp_p),     32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single request: 3 * -2 from requester 0.
    req_a     = {4'h0, 4'h3};
    req_b     = {4'h0, 4'hE};
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    check("single_mul_a",   32'(mul_a),     32'h3);
    check("single_mul_b",   32'(mul_b),     32'hE);
    check("single_mul_en",  32'(mul_en),    32'd1);
    check("single_busy",    32'(busy),      32'd1);
    check("single_ready_run", 32'(req_ready), 32'h0);
    wait_rsp(n);
    check("single_latency", 32'(n),         32'd6);
    check("single_rsp_p",   32'(rsp_p),     32'h7A);
    check("single_rsp_id",  32'(rsp_id),    32'd0);
    check("single_en_off",  32'(mul_en),    32'd0);
    tick();
    check("single_rsp_clr", 32'(rsp_valid), 32'd0);
    check("single_idle",    32'(busy),      32'd0);
    check("single_hold_a",  32'(mul_a),     32'h3);

    // Simultaneous requests straight after reset: requester 0 first.
    pulse_reset();
    req_a     = {4'hD, 4'h2};
    req_b     = {4'h2, 4'h3};
    req_valid = 2'b11;
    #1;
    check("tie_ready0", 32'(req_ready), 32'h1);
    tick();
    t0 = cyc;
    wait_rsp(n);
    check("tie_rsp_p0",  32'(rsp_p),  32'h06);
    check("tie_rsp_id0", 32'(rsp_id), 32'd0);
    tick();
    check("tie_ready1", 32'(req_ready), 32'h2);
    tick();
    check("tie_gap",    32'(cyc - t0), 32'd8);
    check("tie_mul_a1", 32'(mul_a),    32'hD);
    wait_rsp(n);
    check("tie_rsp_p1",  32'(rsp_p),  32'h7A);
    check("tie_rsp_id1", 32'(rsp_id), 32'd1);
    tick();

    // Fairness: both held valid, grants must alternate starting with 0.
    for (int k = 0; k < 6; k++) begin
      exp_id = k[0];
      req_a  = exp_id ? {op_a[k], 4'h1} : {4'h1, op_a[k]};
      req_b  = exp_id ? {op_b[k], 4'h1} : {4'h1, op_b[k]};
      #1;
      check("fair_ready", 32'(req_ready), exp_id ? 32'h2 : 32'h1);
      tick();
      wait_rsp(n);
      check("fair_rsp_id", 32'(rsp_id), 32'(exp_id));
      check("fair_rsp_p",  32'(rsp_p),  32'(op_exp[k]));
      tick();
    end

    // Backpressure with requester 1 pending.
    req_a     = {4'h7, 4'h8};
    req_b     = {4'h7, 4'h8};
    rsp_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(req_ready), 32'h1);
    tick();
    wait_rsp(n);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_p",     32'(rsp_p),     32'h40);
      check("bp_rsp_id",    32'(rsp_id),    32'd0);
      check("bp_ready",     32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_rsp_clr", 32'(rsp_valid), 32'd0);
    check("bp_ready1",  32'(req_ready), 32'h2);
    tick();
    check("bp_accept",  32'(busy),      32'd1);

    // Operand hold: requester inputs churn while the operation runs.
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      req_a = 8'($urandom);
      req_b = 8'($urandom);
      check("hold_mul_a", 32'(mul_a), 32'h7);
      check("hold_mul_b", 32'(mul_b), 32'h7);
      tick();
      n++;
    end
    check("hold_latency", 32'(n),      32'd6);
    check("hold_rsp_p",   32'(rsp_p),  32'h31);
    check("hold_rsp_id",  32'(rsp_id), 32'd1);
    tick();

    // Reset in the middle of RUN (cnt==2) after requester 0 was served.
    req_a     = {4'h1, 4'h3};
    req_b     = {4'h1, 4'h3};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_mul_a",     32'(mul_a),     32'd0);
    check("mid_rst_mul_b",     32'(mul_b),     32'd0);
    check("mid_rst_mul_en",    32'(mul_en),    32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_p",     32'(rsp_p),     32'd0);
    check("mid_rst_rsp_id",    32'(rsp_id),    32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_a     = {4'hD, 4'h2};
    req_b     = {4'h2, 4'h3};
    req_valid = 2'b11;
    #1;
    check("mid_rst_tie", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    check("mid_rst_mul_a_new", 32'(mul_a), 32'h2);
    wait_rsp(n);
    check("mid_rst_rsp_p_new", 32'(rsp_p), 32'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
